// File: rtl/stream_demux_pkg.sv
// Shared constants and state encoding for the stream_demux block.
package stream_demux_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/stream_demux_sat_cnt.sv
// CNT_W-bit saturating event counter; holds at CNT_MAX until reset.
module stream_demux_sat_cnt
    import stream_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N valid/ready stream demultiplexer with a single-entry output stage.
// Per-channel delivered-beat counters are built only when STREAM_DEMUX_CNT_EN is defined.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int   N_OUT  = 4,
    parameter int   DATA_W = 8,
    localparam int  SEL_W  = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   err,
    output logic [N_OUT*CNT_W-1:0] cnt
);

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   data_q;
    logic [SEL_W-1:0]    dest_q;
    logic                sel_ok;
    logic                accept;
    logic                load;
    logic                drain;

    assign sel_ok   = (int'(in_sel) < N_OUT);
    assign drain    = (state_q == ST_FULL) && out_ready[dest_q];
    assign in_ready = !flush && ((state_q == ST_EMPTY) || out_ready[dest_q]);
    assign accept   = in_valid && in_ready;
    assign load     = accept && sel_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush wins over everything; a valid load wins over a drain so the stage refills in the same cycle.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (load) begin
            state_d = ST_FULL;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        out_valid = '0;
        if (state_q == ST_FULL) begin
            out_valid[dest_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            dest_q <= '0;
            err    <= 1'b0;
        end else begin
            err <= accept && !sel_ok;
            if (load) begin
                data_q <= in_data;
                dest_q <= in_sel;
            end
        end
    end

    assign out_data = data_q;

`ifdef STREAM_DEMUX_CNT_EN
    for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
        stream_demux_sat_cnt u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (drain && !flush && (int'(dest_q) == i)),
            .count (cnt[CNT_W*i +: CNT_W])
        );
    end
`else
    assign cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Randomized scoreboard bench for stream_demux with a queue-based reference model.
module tb_stream_demux;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int SW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_sel;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [DW-1:0]   out_data;
    logic            err;
    logic [N*16-1:0] cnt;

    stream_demux #(.N_OUT(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           dest;
        logic [DW-1:0] data;
    } beat_t;

    beat_t mq[$];
    int    exp_cnt [N];
    logic  err_pend = 1'b0;
    int    vectors  = 0;
    int    miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard: compare the DUT against the model's view of this cycle, then advance the model by one edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_v;
        logic         exp_rdy;
        beat_t        b;
        if (rst) begin
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_err", 64'(err), 64'(0));
            chk("rst_cnt", 64'(cnt), 64'(0));
            mq.delete();
            err_pend = 1'b0;
            for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        end else begin
            exp_v = '0;
            if (mq.size() > 0) exp_v[mq[0].dest] = 1'b1;
            chk("out_valid", 64'(out_valid), 64'(exp_v));
            if (mq.size() > 0) chk("out_data", 64'(out_data), 64'(mq[0].data));
            exp_rdy = !flush && (mq.size() == 0 || out_ready[mq[0].dest]);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("err", 64'(err), 64'(err_pend));
            for (int i = 0; i < N; i++) chk("cnt", 64'(cnt[16*i +: 16]), 64'(exp_cnt[i]));

            err_pend = 1'b0;
            if (flush) begin
                if (mq.size() > 0) mq.delete();
            end else begin
                if (mq.size() > 0 && out_ready[mq[0].dest]) begin
`ifdef STREAM_DEMUX_CNT_EN
                    if (exp_cnt[mq[0].dest] < 65535) exp_cnt[mq[0].dest]++;
`endif
                    void'(mq.pop_front());
                end
                if (in_valid && exp_rdy) begin
                    if (int'(in_sel) < N) begin
                        b.dest = int'(in_sel);
                        b.data = in_data;
                        mq.push_back(b);
                    end else begin
                        err_pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] d, input int s,
                       input logic [N-1:0] r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_sel    = SW'(s);
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [N-1:0] r);
        repeat (n) cyc(1'b0, '0, 0, r, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // basic route to highest channel
        cyc(1'b1, 8'hA5, 2, '1, 1'b0);
        idle(2, '1);

        // backpressure, then release in the same cycle as the next accept
        cyc(1'b1, 8'h11, 1, '0, 1'b0);
        idle(5, '0);
        cyc(1'b1, 8'h22, 0, 3'b010, 1'b0);
        idle(2, '1);

        // streaming, alternating destinations
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'(i + 8'h30), i % 2, '1, 1'b0);
        idle(2, '1);

        // invalid select, single and back-to-back
        cyc(1'b1, 8'h3C, 3, '1, 1'b0);
        idle(2, '1);
        cyc(1'b1, 8'h3D, 3, '1, 1'b0);
        cyc(1'b1, 8'h3E, 3, '1, 1'b0);
        idle(2, '1);

        // flush while FULL, with a competing valid beat and ready consumer
        cyc(1'b1, 8'h55, 2, '0, 1'b0);
        cyc(1'b1, 8'h66, 0, '1, 1'b1);
        idle(2, '1);

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3),
                N'($urandom), $urandom_range(0, 15) == 0);
        idle(2, '1);

        // asynchronous reset with a beat held for channel 2
        cyc(1'b1, 8'h77, 2, '0, 1'b0);
        idle(1, '0);
        rst = 1'b1;
        idle(2, '0);
        rst = 1'b0;
        idle(2, '1);

        // drive channel 0 past counter saturation
        for (int i = 0; i < 65600; i++) cyc(1'b1, DW'($urandom), 0, '1, 1'b0);
        idle(3, '1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-N stream demultiplexer with valid/ready handshake; the inverse of the team's 2:1 mux-tree selection blocks.
- Accepts one beat per cycle with a destination select and steers it to exactly one of N output channels.
- Single-entry output stage holding one beat, 1-cycle latency, full throughput.
- Sits between a producer stream and N independent consumers.

Parameters:
- N_OUT, 4, number of output channels (2..16).
- DATA_W, 8, beat width in bits.
- SEL_W, $clog2(N_OUT), select width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous and active-high. The clock is named clk and the reset rst.
- flush  input  1  synchronous discard of the held beat.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  DATA_W  beat payload.
- in_sel  input  SEL_W  destination channel index, sampled with in_data.
- out_valid  output  N_OUT  one-hot per-channel valid.
- out_ready  input  N_OUT  per-channel consumer ready.
- out_data  output  DATA_W  shared payload bus, meaningful for the channel whose out_valid is high.
- err  output  1  one-cycle pulse when a beat with in_sel >= N_OUT was consumed.
- cnt  output  N_OUT*16  per-channel delivered-beat counters, channel i at bits [16*i+15:16*i].

Behaviour:
- State: full flag, data_q, dest_q.
  - EMPTY (full=0): no output is valid.
  - FULL (full=1): out_valid[dest_q]=1, all other out_valid bits 0, out_data=data_q.
- Reset (asynchronous assert): full=0, data_q=0, dest_q=0, out_valid=0, out_data=0, err=0, cnt=0. A beat held when reset asserts is lost. The first accept is possible on the first clk edge after rst deasserts.
- in_ready = !flush && (!full || out_ready[dest_q]).
  - This is a combinational path from out_ready to in_ready and is permitted.
- accept = in_valid && in_ready. drain = full && out_ready[dest_q].
- Accept with in_sel < N_OUT: on the next edge data_q=in_data, dest_q=in_sel, full=1. Latency from accept to out_valid is 1 cycle.
- Accept with in_sel >= N_OUT:
  - The beat is consumed and not stored.
  - err=1 for exactly the following cycle.
  - full becomes 0 if draining, otherwise is unchanged.
- Drain without accept: full becomes 0.
- Drain and valid accept in the same cycle: full stays 1 and the new beat replaces the old one. Back-to-back throughput is 1 beat/cycle, including a change of destination.
- out_valid/out_data stability: once asserted, they stay stable until drain, flush or rst. out_valid never depends combinationally on out_ready.
- out_ready bits of non-selected channels are ignored.
- flush=1:
  - full becomes 0 on the next edge, and the held beat is dropped without counting.
  - in_ready=0 that cycle.
  - flush takes priority over a simultaneous drain: the beat is not counted, but the consumer may have sampled it. Consumers must not rely on delivery during a flush.
- err is registered and never asserts two cycles in a row unless two invalid beats are accepted back-to-back.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- Defined: cnt[i] increments by 1 on each drain to channel i. It saturates at 0xFFFF, holds there, and is cleared only by rst.
- Undefined: the cnt port still exists and is tied to all-zero. No counter flops are generated.

Decomposition:
- Package stream_demux_pkg: CNT_W=16 constant, the CNT_MAX constant, and a state typedef (ST_EMPTY, ST_FULL) for waveform readability.
- One natural sub-module: stream_demux_sat_cnt, a CNT_W saturating counter with inc input and asynchronous active-high rst. It is instantiated N_OUT times in a generate loop under STREAM_DEMUX_CNT_EN.

Test Plan:
- Reset: assert rst mid-stream with full=1, dest_q=2 -> out_valid=0000 immediately and err=0; after release, in_ready=1 and cnt=0.
- Basic route: in_data=0xA5, in_sel=3, out_ready=1111 -> next cycle out_valid=1000 and out_data=0xA5; cnt[3]=1 after the drain edge.
- Backpressure: beat 0x11 to channel 1 with out_ready=0000 for 5 cycles -> out_valid=0010 and out_data=0x11 stable throughout, in_ready=0; release out_ready[1] -> in_ready=1 in the same cycle.
- Streaming: 8 beats alternating sel 0,1,0,1 with all ready -> one beat per cycle, no bubbles, final cnt[0]=4 and cnt[1]=4.
- Invalid select (N_OUT=3, in_sel=3): beat consumed, out_valid stays 000, err=1 for one cycle, counters unchanged.
- Flush and saturation: a flush while FULL gives out_valid=0 next cycle, in_ready=0 during the flush cycle, and no count. Preload 65535 drains to channel 0, then one more -> cnt[0] stays 0xFFFF (macro defined), or cnt=0 throughout (macro undefined).
